// File: rtl/div_pkg.sv
// Shared types for the shift/subtract divider: FSM state encoding
// and the default operand width.
package div_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, dvd} left by one,
// compare/subtract the divisor, shift the quotient bit into dvd.
// Ports: rem_in/dvd_in/dsr in, rem_out/dvd_out next values.
module div_step
  import div_pkg::*;
#(
  parameter int n = DIV_W
) (
  input  logic [n:0]   rem_in,
  input  logic [n-1:0] dvd_in,
  input  logic [n-1:0] dsr,
  output logic [n:0]   rem_out,
  output logic [n-1:0] dvd_out
);

  logic [n:0] sh;
  logic [n:0] diff;
  logic       ge;

  always_comb begin
    sh      = {rem_in[n-1:0], dvd_in[n-1]};
    diff    = sh - {1'b0, dsr};
    // a set top bit means the shifted value already exceeds any divisor
    ge      = rem_in[n] | (sh >= {1'b0, dsr});
    rem_out = ge ? diff : sh;
    dvd_out = {dvd_in[n-2:0], ge};
  end

endmodule

// File: rtl/shift_sub_divide.sv
// Multi-cycle restoring divider: n steps per division, one per clock.
// Ports: clk, rst (sync, active-high), start, dividend, divisor in;
// quotient, remainder, busy, done, div_by_zero out.
// Define SHIFT_SUB_DIVIDE_SIGNED_EN for two's-complement operands.
module shift_sub_divide
  import div_pkg::*;
#(
  parameter int n = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  state_t state_q;
  state_t state_d;

  logic [n:0]    rem_q;
  logic [n:0]    rem_nx;
  logic [n-1:0]  dvd_q;
  logic [n-1:0]  dvd_nx;
  logic [n-1:0]  dsr_q;
  logic [CW-1:0] cnt_q;
  logic          dz_q;

  logic [n-1:0]  dvd_mag;
  logic [n-1:0]  dsr_mag;
  logic [n-1:0]  q_fix;
  logic [n-1:0]  r_src;
  logic [n-1:0]  r_fix;

  // on divide-by-zero dvd_q still holds the captured dividend
  assign r_src = dz_q ? dvd_q : rem_q[n-1:0];

`ifdef SHIFT_SUB_DIVIDE_SIGNED_EN
  logic negq_q;
  logic negr_q;

  assign dvd_mag = dividend[n-1] ? -dividend : dividend;
  assign dsr_mag = divisor[n-1] ? -divisor : divisor;
  assign q_fix   = dz_q ? '1 : (negq_q ? -dvd_q : dvd_q);
  assign r_fix   = negr_q ? -r_src : r_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      negq_q <= dividend[n-1] ^ divisor[n-1];
      negr_q <= dividend[n-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
  assign q_fix   = dz_q ? '1 : dvd_q;
  assign r_fix   = r_src;
`endif

  div_step #(
    .n(n)
  ) u_step (
    .rem_in (rem_q),
    .dvd_in (dvd_q),
    .dsr    (dsr_q),
    .rem_out(rem_nx),
    .dvd_out(dvd_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= dvd_mag;
            dsr_q <= dsr_mag;
            rem_q <= '0;
            cnt_q <= CW'(n - 1);
            dz_q  <= (divisor == '0);
            busy  <= 1'b1;
          end
        end
        RUN: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        DONE: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz_q;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divide.sv
// Self-checking bench for shift_sub_divide at n=8: directed cases
// plus randomized traffic against a cycle-level arithmetic model.
module tb_shift_sub_divide;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  shift_sub_divide #(
    .n(N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // {quotient, remainder} from plain arithmetic
  function automatic logic [15:0] ref_div(input logic [7:0] a,
                                          input logic [7:0] b);
    int sa;
    int sb;
    logic [7:0] q;
    logic [7:0] r;
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
    end else begin
`ifdef SHIFT_SUB_DIVIDE_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
    return {q, r};
  endfunction

  // model: accepted when idle, finishes after a fixed latency
  int          cyc = 0;
  int          m_idle_from = 0;
  int          m_done_cyc = 0;
  bit          m_pend = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [7:0]  m_q = '0;
  logic [7:0]  m_r = '0;
  logic        m_dz = 1'b0;
  logic [15:0] m_pqr = '0;
  logic        m_pdz = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_pend      <= 1'b0;
      m_busy      <= 1'b0;
      m_done      <= 1'b0;
      m_q         <= '0;
      m_r         <= '0;
      m_dz        <= 1'b0;
      m_idle_from <= cyc + 1;
    end else begin
      m_done <= 1'b0;
      if (m_pend && cyc == m_done_cyc) begin
        m_done      <= 1'b1;
        m_busy      <= 1'b0;
        m_q         <= m_pqr[15:8];
        m_r         <= m_pqr[7:0];
        m_dz        <= m_pdz;
        m_pend      <= 1'b0;
        m_idle_from <= cyc + 1;
      end else if (!m_pend && cyc >= m_idle_from && start) begin
        m_pend     <= 1'b1;
        m_busy     <= 1'b1;
        m_done_cyc <= cyc + ((divisor == '0) ? 1 : N + 1);
        m_pqr      <= ref_div(dividend, divisor);
        m_pdz      <= (divisor == '0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      if (done || !busy) begin
        chk("quotient", {24'd0, quotient}, {24'd0, m_q});
        chk("remainder", {24'd0, remainder}, {24'd0, m_r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
      end
    end
  end

  int         lat;
  int         bcnt;
  logic [7:0] rq;
  logic [7:0] rr;
  logic       rdz;

  // one request; optional second start pulse at cycle inj
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input int inj);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
      if (inj > 0 && lat == inj) begin
        dividend = 8'd10;
        divisor  = 8'd3;
        start    = 1'b1;
      end
      if (inj > 0 && lat == inj + 1) start = 1'b0;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout waiting for done a=%0d b=%0d", a, b);
    end
    rq  = quotient;
    rr  = remainder;
    rdz = div_by_zero;
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
  endtask

  int ndone;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_q", {24'd0, quotient}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    do_op(8'd100, 8'd7, 0);
    chk("t1_lat", lat, 9);
    chk("t1_busy_cycles", bcnt, 9);
    chk("t1_q", {24'd0, rq}, 32'd14);
    chk("t1_r", {24'd0, rr}, 32'd2);
    chk("t1_dz", {31'd0, rdz}, 32'd0);

    do_op(8'd55, 8'd0, 0);
    chk("t2_lat", lat, 1);
    chk("t2_busy_cycles", bcnt, 1);
    chk("t2_q", {24'd0, rq}, 32'hFF);
    chk("t2_r", {24'd0, rr}, 32'd55);
    chk("t2_dz", {31'd0, rdz}, 32'd1);

    do_op(8'd255, 8'd1, 4);
    chk("t3_lat", lat, 9);
    chk("t3_q", {24'd0, rq}, 32'd255);
    chk("t3_r", {24'd0, rr}, 32'd0);
    @(negedge clk);
    chk("t3_no_second_op", {31'd0, busy}, 32'd0);
    do_op(8'd10, 8'd3, 0);
    chk("t3b_q", {24'd0, rq}, 32'd3);
    chk("t3b_r", {24'd0, rr}, 32'd1);

    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_q", {24'd0, quotient}, 32'd0);
    chk("t4_r", {24'd0, remainder}, 32'd0);
    chk("t4_dz", {31'd0, div_by_zero}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_no_done", ndone, 0);
    do_op(8'd200, 8'd9, 0);
`ifdef SHIFT_SUB_DIVIDE_SIGNED_EN
    chk("t4b_q", {24'd0, rq}, 32'hFA);
    chk("t4b_r", {24'd0, rr}, 32'hFE);
`else
    chk("t4b_q", {24'd0, rq}, 32'd22);
    chk("t4b_r", {24'd0, rr}, 32'd2);
`endif

    do_op(8'h9C, 8'd7, 0);
    chk("t5_lat", lat, 9);
`ifdef SHIFT_SUB_DIVIDE_SIGNED_EN
    chk("t5_q", {24'd0, rq}, 32'hF2);
    chk("t5_r", {24'd0, rr}, 32'hFE);
`else
    chk("t5_q", {24'd0, rq}, 32'd22);
    chk("t5_r", {24'd0, rr}, 32'd2);
`endif
    do_op(8'd100, 8'hF9, 0);
    chk("t6_lat", lat, 9);
`ifdef SHIFT_SUB_DIVIDE_SIGNED_EN
    chk("t6_q", {24'd0, rq}, 32'hF2);
    chk("t6_r", {24'd0, rr}, 32'h02);
`else
    chk("t6_q", {24'd0, rq}, 32'd0);
    chk("t6_r", {24'd0, rr}, 32'd100);
`endif
    do_op(8'd5, 8'd100, 0);
    chk("t7_q", {24'd0, rq}, 32'd0);
    chk("t7_r", {24'd0, rr}, 32'd5);

    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    ndone    = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("t8_held_start_dones", ndone, 2);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) != 0);
      dividend = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        divisor = 8'd0;
      else if ($urandom_range(0, 1) == 1)
        divisor = 8'($urandom_range(1, 15));
      else
        divisor = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
